matrix_op_controller: RTL and testbench
=======================================

MATRIX_OP_CONTROLLER -- requirements
Module: matrix_op_controller

Interface
REQ-001 The block SHALL have parameter ADDR_A, default 8'd0: RAM address of matrix A.
REQ-002 The block SHALL have parameter ADDR_B, default 8'd1: RAM address of matrix B.
REQ-003 The block SHALL have parameter ADDR_R, default 8'd2: RAM address for the result write.
REQ-004 The block SHALL have parameter RD_LAT, default 2: cycles from address change to valid ram_q, range 1..7.
REQ-005 The block SHALL have parameter WR_HOLD, default 3: cycles ram_wren stays high, range 1..15.
REQ-006 The block SHALL have parameter TIMEOUT, default 1023: maximum WAIT_DONE cycles, active only when TIMEOUT_EN is defined.
REQ-007 The block SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port switch, input, 8 bits: one-hot operation select; lowest set bit wins.
REQ-010 The block SHALL have port go, input, 1 bit: request to start one operation; sampled only in IDLE.
REQ-011 The block SHALL have port ram_address, output, 8 bits: RAM address.
REQ-012 The block SHALL have port ram_wren, output, 1 bit: RAM write enable.
REQ-013 The block SHALL have port ram_q, input, 256 bits: RAM read data.
REQ-014 The block SHALL have port matrix_a, output, 200 bits: latched operand A, from ram_q[199:0].
REQ-015 The block SHALL have port matrix_b, output, 200 bits: latched operand B, from ram_q[199:0].
REQ-016 The block SHALL have port operation_code, output, 4 bits: operation latched from switch; 0..7 selects an operation, 15 means none.
REQ-017 The block SHALL have port mul_start, output, 1 bit: one-cycle start pulse to the multiplier.
REQ-018 The block SHALL have port mul_done, input, 1 bit: multiplier completion.
REQ-019 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-020 The block SHALL have port finished, output, 1 bit: one-cycle pulse when the result write completes.
REQ-021 The block SHALL have port error, output, 1 bit: sticky error flag, cleared by reset or by the next accepted go.

Function
REQ-022 The FSM SHALL have states IDLE, RD_A, RD_B, LAUNCH, WAIT_DONE, WRITE and DONE, and SHALL be encoded as a single state register.
REQ-023 In IDLE, go=1 with switch!=0 SHALL latch operation_code (lowest set bit index), set ram_address=ADDR_A, clear error, and enter RD_A on the next cycle.
REQ-024 In IDLE, go=1 with switch==0 SHALL set error=1 and keep the FSM in IDLE.
REQ-025 RD_A SHALL count RD_LAT cycles, then capture matrix_a<=ram_q[199:0], set ram_address=ADDR_B, and enter RD_B.
REQ-026 RD_B SHALL count RD_LAT cycles, then capture matrix_b and enter LAUNCH.
REQ-027 LAUNCH SHALL last one cycle; if operation_code==2 it SHALL drive mul_start=1 for exactly that cycle and go to WAIT_DONE, otherwise it SHALL go to WRITE.
REQ-028 WAIT_DONE SHALL hold until mul_done=1, then enter WRITE.
REQ-029 mul_done already high in the LAUNCH cycle SHALL be ignored.
REQ-030 On entry to WRITE, ram_address SHALL be set to ADDR_R, and ram_wren SHALL be high for exactly WR_HOLD consecutive cycles, then low.
REQ-031 After WRITE the FSM SHALL enter DONE, assert finished=1 for one cycle, and return to IDLE.
REQ-032 Minimum latency from go to finished for a non-multiply operation SHALL be 2*RD_LAT + WR_HOLD + 3 cycles.
REQ-033 switch changes after go is accepted SHALL NOT affect operation_code until the next IDLE acceptance.
REQ-034 go asserted while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-035 Counters SHALL be sized to their parameters and SHALL reset to 0 on every state entry.
REQ-036 ram_wren SHALL never be high outside WRITE.

Reset
REQ-037 A synchronous reset=1 SHALL force IDLE from any state, including mid-WRITE, on the next edge.
REQ-038 Reset SHALL force ram_wren=0, mul_start=0, busy=0, finished=0, error=0, ram_address=ADDR_A, matrix_a=0, matrix_b=0, operation_code=15 and all counters to 0.
REQ-039 When reset deasserts, the FSM SHALL accept go no earlier than the next cycle.

Configuration
REQ-040 With TIMEOUT_EN defined, WAIT_DONE longer than TIMEOUT cycles SHALL set error=1, skip WRITE (no ram_wren), and return to IDLE with no finished pulse.
REQ-041 Without TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, and no timeout counter logic SHALL exist.

Verification
REQ-042 switch=8'b0000_0001, go pulse, RD_LAT=2, WR_HOLD=3 -> matrix_a/matrix_b = RAM[0]/RAM[1], ram_wren high 3 cycles at address 2, finished 10 cycles after go.
REQ-043 switch=8'b0000_0100, go pulse, mul_done raised 20 cycles after mul_start -> exactly one mul_start pulse, write begins the cycle after mul_done.
REQ-044 switch=8'b0001_0010 -> operation_code=1; switch=0 with go -> error=1, busy stays 0.
REQ-045 reset asserted during the second ram_wren cycle -> ram_wren=0 and busy=0 the next cycle, no finished pulse.
REQ-046 go held high through the whole operation -> exactly one operation per IDLE acceptance; a second run starts only after finished.
REQ-047 TIMEOUT_EN defined, TIMEOUT=15, mul_done never asserted -> error=1 after 16 WAIT_DONE cycles, no ram_wren, FSM back in IDLE.

Source files
------------

// File: rtl/matrix_op_controller_if.sv
// matrix_op_controller_if: operation request, RAM bus, multiplier handshake and
// status signals of the matrix operation controller.
// master = the controller, slave = the surrounding system (RAM, multiplier, host).
interface matrix_op_controller_if;
    logic [7:0]   switch;
    logic         go;
    logic [7:0]   ram_address;
    logic         ram_wren;
    logic [255:0] ram_q;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic [3:0]   operation_code;
    logic         mul_start;
    logic         mul_done;
    logic         busy;
    logic         finished;
    logic         error;

    modport master (
        input  switch, go, ram_q, mul_done,
        output ram_address, ram_wren, matrix_a, matrix_b, operation_code,
               mul_start, busy, finished, error
    );

    modport slave (
        output switch, go, ram_q, mul_done,
        input  ram_address, ram_wren, matrix_a, matrix_b, operation_code,
               mul_start, busy, finished, error
    );
endinterface

// File: rtl/matrix_op_controller.sv
// matrix_op_controller: reads operands A and B from RAM, pulses the multiplier
// for the multiply operation (code 2), then holds the result write for WR_HOLD
// cycles and pulses finished.
// Optional feature: define TIMEOUT_EN to abort WAIT_DONE after TIMEOUT+1 cycles
// with error set and no result write.
module matrix_op_controller #(
    parameter logic [7:0] ADDR_A  = 8'd0,
    parameter logic [7:0] ADDR_B  = 8'd1,
    parameter logic [7:0] ADDR_R  = 8'd2,
    parameter int         RD_LAT  = 2,
    parameter int         WR_HOLD = 3,
    parameter int         TIMEOUT = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    matrix_op_controller_if.master bus
);
    // One shared phase counter serves RD_A, RD_B and WRITE.
    localparam int            MAXC    = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
    localparam int            CW      = $clog2(MAXC + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_HOLD - 1);
    localparam logic [3:0]    OP_MUL  = 4'd2;
    localparam logic [3:0]    OP_NONE = 4'hF;

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, LAUNCH, WAIT_DONE, WRITE, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    addr_q;
    logic [199:0]  mat_a_q, mat_b_q;
    logic [3:0]    op_q;
    logic          err_q;
    logic          accept;
    logic          timeout;
    logic          unused_q;

    // Bits above the 200-bit operand are not part of the matrix payload.
    assign unused_q = ^bus.ram_q[255:200];

    function automatic logic [3:0] lowest_bit(input logic [7:0] s);
        lowest_bit = OP_NONE;
        for (int i = 7; i >= 0; i--)
            if (s[i]) lowest_bit = 4'(i);
    endfunction

    assign accept = (state == IDLE) && bus.go && (bus.switch != 8'd0);

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // WAIT_DONE cycle counter, restarted on every state change.
    always_ff @(posedge clock) begin
        if (reset || state_nxt != state) tcnt <= '0;
        else if (state == WAIT_DONE)     tcnt <= tcnt + TW'(1);
    end

    // Fires in the (TIMEOUT+1)-th WAIT_DONE cycle; mul_done in that cycle still wins.
    assign timeout = (state == WAIT_DONE) && !bus.mul_done && (tcnt == TW'(TIMEOUT));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept) state_nxt = RD_A;
            RD_A:      if (cnt == RD_LAST) state_nxt = RD_B;
            RD_B:      if (cnt == RD_LAST) state_nxt = LAUNCH;
            // mul_done is not looked at here, so a stale done cannot skip the wait.
            LAUNCH:    state_nxt = (op_q == OP_MUL) ? WAIT_DONE : WRITE;
            WAIT_DONE: if (bus.mul_done) state_nxt = WRITE;
                       else if (timeout) state_nxt = IDLE;
            WRITE:     if (cnt == WR_LAST) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register, phase counter, address and operand/opcode/error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= ADDR_A;
            mat_a_q <= '0;
            mat_b_q <= '0;
            op_q    <= OP_NONE;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)                  cnt <= '0;
            else if (state inside {RD_A, RD_B, WRITE}) cnt <= cnt + CW'(1);

            if (state == IDLE && bus.go) begin
                if (accept) begin
                    op_q   <= lowest_bit(bus.switch);
                    addr_q <= ADDR_A;
                    err_q  <= 1'b0;
                end else begin
                    err_q  <= 1'b1;
                end
            end
            if (timeout) err_q <= 1'b1;

            if (state == RD_A && cnt == RD_LAST) begin
                mat_a_q <= bus.ram_q[199:0];
                addr_q  <= ADDR_B;
            end
            if (state == RD_B && cnt == RD_LAST) mat_b_q <= bus.ram_q[199:0];
            if (state_nxt == WRITE && state != WRITE) addr_q <= ADDR_R;
        end
    end

    assign bus.ram_address    = addr_q;
    assign bus.ram_wren       = (state == WRITE);
    assign bus.matrix_a       = mat_a_q;
    assign bus.matrix_b       = mat_b_q;
    assign bus.operation_code = op_q;
    assign bus.mul_start      = (state == LAUNCH) && (op_q == OP_MUL);
    assign bus.busy           = (state != IDLE);
    assign bus.finished       = (state == DONE);
    assign bus.error          = err_q;
endmodule

// File: tb/tb_matrix_op_controller.sv
// tb_matrix_op_controller: directed checks of the matrix operation controller
// with a 2-cycle-latency RAM model and a hand-driven multiplier done line.
// Build with TIMEOUT_EN defined to also exercise the WAIT_DONE timeout.
module tb_matrix_op_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;

    matrix_op_controller_if bif ();

    matrix_op_controller #(
        .ADDR_A(8'd0), .ADDR_B(8'd1), .ADDR_R(8'd2),
        .RD_LAT(2), .WR_HOLD(3), .TIMEOUT(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif.master)
    );

    always #5 clock = ~clock;

    // RAM content: a distinct byte pattern per address, including the unused top bits.
    function automatic logic [255:0] pat(input int a);
        for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(a * 37 + i * 11 + 1);
    endfunction

    // Address registered once, data registered once: ram_q valid 2 cycles after an address change.
    logic [255:0] q_reg = '0;
    always @(posedge clock) q_reg <= pat(int'(bif.ram_address));
    assign bif.ram_q = q_reg;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Per-run observations; cycle 1 is the cycle in which go is first driven.
    int fin_cyc, fin_cnt, idle_cyc, wr_cnt, wr_first, ms_cnt, ms_cyc;
    bit addr_bad, budget_ok;

    task automatic run_op(input logic [7:0] sw, input bit hold_go, input int mul_dly,
                          input bit early_done);
        int cyc;
        fin_cyc = -1; fin_cnt = 0; idle_cyc = -1; wr_cnt = 0; wr_first = -1;
        ms_cnt = 0; ms_cyc = -1; addr_bad = 0;
        bif.switch = sw;
        bif.go     = 1'b1;
        cyc = 1;
        while (idle_cyc < 0 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (bif.ram_wren) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = cyc;
                if (bif.ram_address !== 8'd2) addr_bad = 1;
                bif.mul_done = 1'b0;
            end
            if (bif.finished) begin fin_cnt++; fin_cyc = cyc; end
            if (!bif.busy) idle_cyc = cyc;
            if (early_done && ms_cyc >= 0 && cyc == ms_cyc + 1) bif.mul_done = 1'b0;
            if (bif.mul_start) begin
                ms_cnt++;
                ms_cyc = cyc;
                if (early_done) bif.mul_done = 1'b1;
            end
            if (mul_dly > 0 && ms_cyc >= 0 && cyc == ms_cyc + mul_dly) bif.mul_done = 1'b1;
            // A changed switch after acceptance must not reach operation_code.
            if (cyc == 2 && !hold_go) begin bif.go = 1'b0; bif.switch = 8'h80; end
        end
        budget_ok = (cyc < 300);
        bif.mul_done = 1'b0;
        if (!hold_go) bif.go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        bif.switch = 8'd0; bif.go = 1'b0; bif.mul_done = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_busy",   256'(bif.busy), 256'(0));
        chk("rst_wren",   256'(bif.ram_wren), 256'(0));
        chk("rst_mstart", 256'(bif.mul_start), 256'(0));
        chk("rst_fin",    256'(bif.finished), 256'(0));
        chk("rst_err",    256'(bif.error), 256'(0));
        chk("rst_addr",   256'(bif.ram_address), 256'(0));
        chk("rst_mata",   256'(bif.matrix_a), 256'(0));
        chk("rst_opc",    256'(bif.operation_code), 256'(15));
        reset = 1'b0;
        @(negedge clock);

        // Plain operation 0: latency 2*2+3+3 = 10, write in cycles 7..9 at address 2
        run_op(8'h01, 1'b0, 0, 1'b0);
        chk("op0_budget", 256'(budget_ok), 256'(1));
        chk("op0_fin",    256'(fin_cyc), 256'(10));
        chk("op0_idle",   256'(idle_cyc), 256'(11));
        chk("op0_wrcnt",  256'(wr_cnt), 256'(3));
        chk("op0_wrfst",  256'(wr_first), 256'(7));
        chk("op0_waddr",  256'(addr_bad), 256'(0));
        chk("op0_mstart", 256'(ms_cnt), 256'(0));
        chk("op0_mata",   256'(bif.matrix_a), 256'(pat(0)) & {56'd0, {200{1'b1}}});
        chk("op0_matb",   256'(bif.matrix_b), 256'(pat(1)) & {56'd0, {200{1'b1}}});
        chk("op0_opc",    256'(bif.operation_code), 256'(0));

        // Multiply: done raised 20 cycles after the start pulse (cycle 6)
        run_op(8'h04, 1'b0, 20, 1'b0);
        chk("mul_budget", 256'(budget_ok), 256'(1));
        chk("mul_mscnt",  256'(ms_cnt), 256'(1));
        chk("mul_mscyc",  256'(ms_cyc), 256'(6));
        chk("mul_wrfst",  256'(wr_first), 256'(27));
        chk("mul_wrcnt",  256'(wr_cnt), 256'(3));
        chk("mul_fin",    256'(fin_cyc), 256'(30));
        chk("mul_opc",    256'(bif.operation_code), 256'(2));

        // Multiply with a stray done pulse during LAUNCH: must still wait for the real one
        run_op(8'h04, 1'b0, 5, 1'b1);
        chk("early_mscnt", 256'(ms_cnt), 256'(1));
        chk("early_wrfst", 256'(wr_first), 256'(12));
        chk("early_fin",   256'(fin_cyc), 256'(15));

        // Lowest set bit selects the operation
        run_op(8'h12, 1'b0, 0, 1'b0);
        chk("low_opc", 256'(bif.operation_code), 256'(1));
        chk("low_fin", 256'(fin_cyc), 256'(10));

        // go with empty switch: error, stays idle
        bif.switch = 8'h00; bif.go = 1'b1;
        @(negedge clock);
        bif.go = 1'b0;
        chk("zero_err",  256'(bif.error), 256'(1));
        chk("zero_busy", 256'(bif.busy), 256'(0));
        @(negedge clock);
        chk("zero_busy2", 256'(bif.busy), 256'(0));
        chk("zero_opc",   256'(bif.operation_code), 256'(1));

        // Next accepted go clears the error
        run_op(8'h40, 1'b0, 0, 1'b0);
        chk("clr_err", 256'(bif.error), 256'(0));
        chk("clr_opc", 256'(bif.operation_code), 256'(6));
        chk("clr_fin", 256'(fin_cyc), 256'(10));

        // go held high: one run per acceptance, re-accept only after finished
        run_op(8'h08, 1'b1, 0, 1'b0);
        chk("hold_fincnt", 256'(fin_cnt), 256'(1));
        chk("hold_fin",    256'(fin_cyc), 256'(10));
        chk("hold_idle",   256'(idle_cyc), 256'(11));
        @(negedge clock);
        chk("hold_rerun", 256'(bif.busy), 256'(1));
        bif.go = 1'b0;
        fin_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (bif.finished) fin_cnt++;
        end
        chk("hold_fincnt2", 256'(fin_cnt), 256'(1));
        chk("hold_busy_end", 256'(bif.busy), 256'(0));

        // Reset during the second write cycle
        bif.switch = 8'h08; bif.go = 1'b1;
        @(negedge clock);
        bif.go = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 20 && wr_cnt < 2; i++) begin
            @(negedge clock);
            if (bif.ram_wren) wr_cnt++;
        end
        chk("rw_reach", 256'(wr_cnt), 256'(2));
        reset = 1'b1;
        @(negedge clock);
        chk("rw_wren", 256'(bif.ram_wren), 256'(0));
        chk("rw_busy", 256'(bif.busy), 256'(0));
        chk("rw_fin",  256'(bif.finished), 256'(0));
        chk("rw_opc",  256'(bif.operation_code), 256'(15));
        chk("rw_addr", 256'(bif.ram_address), 256'(0));
        reset = 1'b0;
        fin_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bif.finished) fin_cnt++;
            if (bif.ram_wren || bif.busy) wr_cnt++;
        end
        chk("rw_nofin", 256'(fin_cnt), 256'(0));
        chk("rw_quiet", 256'(wr_cnt), 256'(0));

`ifdef TIMEOUT_EN
        // Multiply whose done never comes: abort after 16 WAIT_DONE cycles (7..22)
        run_op(8'h04, 1'b0, 0, 1'b0);
        chk("to_budget", 256'(budget_ok), 256'(1));
        chk("to_idle",   256'(idle_cyc), 256'(23));
        chk("to_wrcnt",  256'(wr_cnt), 256'(0));
        chk("to_fincnt", 256'(fin_cnt), 256'(0));
        chk("to_err",    256'(bif.error), 256'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
